// File: rtl/goertzel_pkg.sv
// Shared fixed-point types and constants (signed 20.44) for the Goertzel coefficient generator.
// Pure constants: no latency, no flow control.
package goertzel_pkg;

   localparam int  FW = 44;
   localparam int  DW = 64;
   localparam real ONE_R = 2.0 ** FW;
   localparam real PI_R  = 3.14159265358979323846;

   typedef logic signed [DW-1:0] fix_t;

   typedef enum logic [2:0] {IDLE, LOAD, ROT, STORE, DONE} state_t;

   localparam fix_t PI            = fix_t'(longint'(PI_R * ONE_R));
   localparam fix_t HALF_PI       = fix_t'(longint'(0.5 * PI_R * ONE_R));
   localparam fix_t THREE_HALF_PI = fix_t'(longint'(1.5 * PI_R * ONE_R));
   localparam fix_t TWO_PI        = fix_t'(longint'(2.0 * PI_R * ONE_R));
   localparam fix_t CORDIC_K      = fix_t'(longint'(0.6072529350088813 * ONE_R));

   // From i = 11 on, atan(2^-i) = 2^-i - 2^-3i/3 is exact to well below one LSB.
   localparam fix_t ATAN_TAB [0:43] = '{
      fix_t'(longint'(0.7853981633974483    * ONE_R)),
      fix_t'(longint'(0.4636476090008061    * ONE_R)),
      fix_t'(longint'(0.24497866312686414   * ONE_R)),
      fix_t'(longint'(0.12435499454676144   * ONE_R)),
      fix_t'(longint'(0.06241880999595735   * ONE_R)),
      fix_t'(longint'(0.031239833430268277  * ONE_R)),
      fix_t'(longint'(0.015623728620476831  * ONE_R)),
      fix_t'(longint'(0.007812341060101111  * ONE_R)),
      fix_t'(longint'(0.0039062301319669718 * ONE_R)),
      fix_t'(longint'(0.0019531225164788188 * ONE_R)),
      fix_t'(longint'(0.0009765621895593195 * ONE_R)),
      64'sd8589933909, 64'sd4294967211, 64'sd2147483637, 64'sd1073741823,
      64'sd536870912,  64'sd268435456,  64'sd134217728,  64'sd67108864,
      64'sd33554432,   64'sd16777216,   64'sd8388608,    64'sd4194304,
      64'sd2097152,    64'sd1048576,    64'sd524288,     64'sd262144,
      64'sd131072,     64'sd65536,      64'sd32768,      64'sd16384,
      64'sd8192,       64'sd4096,       64'sd2048,       64'sd1024,
      64'sd512,        64'sd256,        64'sd128,        64'sd64,
      64'sd32,         64'sd16,         64'sd8,          64'sd4,
      64'sd2
   };

endpackage

// File: rtl/goertzel_coef_gen_cordic_stage.sv
// One rotation-mode CORDIC micro-rotation (x, y, z, i -> next x, y, z).
// Purely combinational: zero latency, no flow control.
module cordic_stage
   import goertzel_pkg::*;
(
   input  logic signed [DW-1:0] x,
   input  logic signed [DW-1:0] y,
   input  logic signed [DW-1:0] z,
   input  logic [5:0]           i,
   output logic signed [DW-1:0] x_nxt,
   output logic signed [DW-1:0] y_nxt,
   output logic signed [DW-1:0] z_nxt
);

   fix_t x_sh;
   fix_t y_sh;
   fix_t atan;

   always_comb begin
      x_sh = x >>> i;
      y_sh = y >>> i;
      atan = ATAN_TAB[i];
      // Rotate toward z = 0; z >= 0 means counter-clockwise (d = +1).
      if (!z[DW-1]) begin
         x_nxt = x - y_sh;
         y_nxt = y + x_sh;
         z_nxt = z - atan;
      end else begin
         x_nxt = x + y_sh;
         y_nxt = y - x_sh;
         z_nxt = z + atan;
      end
   end

endmodule

// File: rtl/goertzel_coef_gen.sv
// Converts NF bin angles to cos/sin/2cos with one shared iterative CORDIC, NF*(N_ITER+2) cycles per run.
// No backpressure: en low aborts a run; valid is sticky until en falls.
module goertzel_coef_gen
   import goertzel_pkg::*;
#(
   parameter int NF     = 11,
   parameter int N_ITER = 40
)
(
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       en,
   input  logic                       ang_valid_i,
   input  logic [NF-1:0][63:0]        angle_i,
   output logic                       valid,
   output logic                       busy,
   output logic                       range_err_o,
   output logic signed [NF-1:0][63:0] cos_o,
   output logic signed [NF-1:0][63:0] sin_o,
   output logic signed [NF-1:0][63:0] coef_o
);

   localparam int IDX_W = (NF > 1) ? $clog2(NF) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NF - 1);
   localparam logic [5:0]       ITER_LAST = 6'(N_ITER - 1);

   state_t              state;
   logic [IDX_W-1:0]    idx;
   logic [5:0]          iter;
   logic [NF-1:0][63:0] snap;
   fix_t                x, y, z;
   logic                neg;

   fix_t x_nxt, y_nxt, z_nxt;
   fix_t a, theta;
   logic quad_neg, ang_err;
   fix_t x_out, y_out;

   cordic_stage u_stage (
      .x     (x),
      .y     (y),
      .z     (z),
      .i     (iter),
      .x_nxt (x_nxt),
      .y_nxt (y_nxt),
      .z_nxt (z_nxt)
   );

   // Fold the angle into [-pi/2, pi/2) where CORDIC converges; pi shift flips both signs.
   always_comb begin
      a        = fix_t'(snap[idx]);
      theta    = '0;
      quad_neg = 1'b0;
      ang_err  = 1'b0;
      if (a[DW-1] || a >= TWO_PI) begin
         ang_err = 1'b1;
      end else if (a < HALF_PI) begin
         theta = a;
      end else if (a < THREE_HALF_PI) begin
         theta    = a - PI;
         quad_neg = 1'b1;
      end else begin
         theta = a - TWO_PI;
      end
      x_out = neg ? -x : x;
      y_out = neg ? -y : y;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         idx         <= '0;
         iter        <= '0;
         snap        <= '0;
         x           <= '0;
         y           <= '0;
         z           <= '0;
         neg         <= 1'b0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         range_err_o <= 1'b0;
         cos_o       <= '0;
         sin_o       <= '0;
         coef_o      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en && ang_valid_i) begin
                  snap        <= angle_i;
                  idx         <= '0;
                  range_err_o <= 1'b0;
                  busy        <= 1'b1;
                  state       <= LOAD;
               end
            end
            LOAD, ROT, STORE: begin
               if (!en) begin
                  busy  <= 1'b0;
                  valid <= 1'b0;
                  state <= IDLE;
               end else if (state == LOAD) begin
                  if (ang_err) range_err_o <= 1'b1;
                  x     <= CORDIC_K;
                  y     <= '0;
                  z     <= theta;
                  neg   <= quad_neg;
                  iter  <= '0;
                  state <= ROT;
               end else if (state == ROT) begin
                  x <= x_nxt;
                  y <= y_nxt;
                  z <= z_nxt;
                  if (iter == ITER_LAST) state <= STORE;
                  else                   iter  <= iter + 6'd1;
               end else begin
                  cos_o[idx]  <= x_out;
                  sin_o[idx]  <= y_out;
                  coef_o[idx] <= x_out <<< 1;
                  if (idx == IDX_LAST) begin
                     valid <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= LOAD;
                  end
               end
            end
            DONE: begin
               if (!en) begin
                  valid <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_goertzel_coef_gen.sv
// Directed runs with random angles, checked against a real-valued trig model of each bin.
module tb_goertzel_coef_gen;

   localparam int  NF     = 11;
   localparam int  N_ITER = 40;
   localparam int  LAT    = NF * (N_ITER + 2);
   localparam real SCALE  = 17592186044416.0;
   localparam real PI_R   = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rstn, en, ang_valid_i;
   logic [NF-1:0][63:0] angle_i;
   logic valid, busy, range_err_o;
   logic signed [NF-1:0][63:0] cos_o, sin_o, coef_o;

   int     vectors = 0;
   int     miscompares = 0;
   longint two_pi_fx;
   longint set_a[NF], set_b[NF], set_c[NF], set_d[NF], set_e[NF];
   int     lat;

   goertzel_coef_gen #(.NF(NF), .N_ITER(N_ITER)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .ang_valid_i (ang_valid_i),
      .angle_i     (angle_i),
      .valid       (valid),
      .busy        (busy),
      .range_err_o (range_err_o),
      .cos_o       (cos_o),
      .sin_o       (sin_o),
      .coef_o      (coef_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_tol(input string tag, input logic signed [63:0] obs, input real expv,
                          input longint tol);
      longint e;
      longint d;
      e = longint'(expv * SCALE);
      d = obs - e;
      if (d < 0) d = -d;
      vectors++;
      assert (d <= tol) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d (+-%0d)", tag, obs, e, tol);
      end
   endtask

   // Out-of-range angles produce the unit vector (cos 1, sin 0).
   function automatic real ref_cos(longint a);
      if (a < 0 || a >= two_pi_fx) return 1.0;
      return $cos(real'(a) / SCALE);
   endfunction

   function automatic real ref_sin(longint a);
      if (a < 0 || a >= two_pi_fx) return 0.0;
      return $sin(real'(a) / SCALE);
   endfunction

   function automatic longint rand_angle();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return longint'(r % 64'(two_pi_fx));
   endfunction

   task automatic check_bins(input int lo, input int hi, input longint angs[NF]);
      for (int b = lo; b <= hi; b++) begin
         chk_tol($sformatf("cos[%0d]", b), cos_o[b], ref_cos(angs[b]), 256);
         chk_tol($sformatf("sin[%0d]", b), sin_o[b], ref_sin(angs[b]), 256);
         chk_tol($sformatf("coef[%0d]", b), coef_o[b], 2.0 * ref_cos(angs[b]), 512);
      end
   endtask

   task automatic drive(input longint angs[NF]);
      for (int b = 0; b < NF; b++) angle_i[b] = angs[b];
   endtask

   // Consumes the start edge, scrambles inputs, then counts edges until valid.
   task automatic wait_done(output int n);
      @(posedge clk); #1;
      chk("busy_after_start", {63'd0, busy}, 64'd1);
      ang_valid_i = 1'b0;
      for (int b = 0; b < NF; b++) angle_i[b] = {$urandom(), $urandom()};
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (valid !== 1'b1 && n < LAT + 100);
   endtask

   task automatic start_and_wait(input longint angs[NF], output int n);
      @(negedge clk);
      drive(angs);
      en = 1'b1;
      ang_valid_i = 1'b1;
      wait_done(n);
   endtask

   task automatic drop_en(input string tag);
      @(negedge clk);
      en = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_valid"}, {63'd0, valid}, 64'd0);
      chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   initial begin
      two_pi_fx   = longint'(2.0 * PI_R * SCALE);
      rstn        = 1'b0;
      en          = 1'b0;
      ang_valid_i = 1'b0;
      angle_i     = '0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_err", {63'd0, range_err_o}, 64'd0);
      chk("rst_cos", {63'd0, |cos_o}, 64'd0);
      chk("rst_sin", {63'd0, |sin_o}, 64'd0);
      chk("rst_coef", {63'd0, |coef_o}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;

      // All-zero angles: unit cosine, exact latency, sticky valid
      for (int b = 0; b < NF; b++) set_a[b] = 0;
      start_and_wait(set_a, lat);
      chk("lat_a", 64'(lat), 64'(LAT));
      chk("busy_done_a", {63'd0, busy}, 64'd0);
      chk("err_a", {63'd0, range_err_o}, 64'd0);
      check_bins(0, NF - 1, set_a);
      repeat (5) @(posedge clk);
      #1;
      chk("valid_held", {63'd0, valid}, 64'd1);
      drop_en("drop_a");
      check_bins(0, 0, set_a);

      // Quadrant boundaries plus random fill
      for (int b = 0; b < NF; b++) set_b[b] = rand_angle();
      set_b[0] = longint'(0.5 * PI_R * SCALE);
      set_b[1] = longint'(PI_R * SCALE);
      set_b[2] = longint'(1.5 * PI_R * SCALE);
      set_b[3] = longint'(0.25 * PI_R * SCALE);
      start_and_wait(set_b, lat);
      chk("lat_b", 64'(lat), 64'(LAT));
      chk("err_b", {63'd0, range_err_o}, 64'd0);
      check_bins(0, NF - 1, set_b);
      drop_en("drop_b");

      // Out-of-range bins: exactly 2pi and -1 LSB
      for (int b = 0; b < NF; b++) set_c[b] = rand_angle();
      set_c[5] = two_pi_fx;
      set_c[6] = -1;
      start_and_wait(set_c, lat);
      chk("lat_c", 64'(lat), 64'(LAT));
      chk("err_c", {63'd0, range_err_o}, 64'd1);
      check_bins(0, NF - 1, set_c);
      drop_en("drop_c");

      // Abort on edge 100: bins 0..1 rewritten, the rest keep run C results
      for (int b = 0; b < NF; b++) set_d[b] = rand_angle();
      @(negedge clk);
      drive(set_d);
      en = 1'b1;
      ang_valid_i = 1'b1;
      @(posedge clk); #1;
      ang_valid_i = 1'b0;
      repeat (98) @(posedge clk);
      drop_en("abort");
      check_bins(0, 1, set_d);
      check_bins(2, NF - 1, set_c);
      start_and_wait(set_d, lat);
      chk("lat_d", 64'(lat), 64'(LAT));
      chk("err_d", {63'd0, range_err_o}, 64'd0);
      check_bins(0, NF - 1, set_d);
      drop_en("drop_d");

      // Reset mid-rotation, then a run straight out of reset
      for (int b = 0; b < NF; b++) set_e[b] = rand_angle();
      @(negedge clk);
      drive(set_e);
      en = 1'b1;
      ang_valid_i = 1'b1;
      repeat (50) @(posedge clk);
      @(negedge clk);
      rstn = 1'b0;
      #1;
      chk("midrst_valid", {63'd0, valid}, 64'd0);
      chk("midrst_busy", {63'd0, busy}, 64'd0);
      chk("midrst_cos", {63'd0, |cos_o}, 64'd0);
      chk("midrst_sin", {63'd0, |sin_o}, 64'd0);
      chk("midrst_coef", {63'd0, |coef_o}, 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      wait_done(lat);
      chk("lat_e", 64'(lat), 64'(LAT));
      check_bins(0, NF - 1, set_e);
      drop_en("drop_e");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/goertzel_coef_gen.md
Name: goertzel_coef_gen

Overview:
- Consumes the per-bin angle array produced upstream (angle_k = ang_coef * k, signed 20.44 radians) and converts each angle into Goertzel coefficients cos(w), sin(w) and 2cos(w).
- Uses one shared iterative CORDIC engine (rotation mode), processing the NF bins sequentially.
- Uses the same en/valid convention as the angle stage.
- Sits between the angle stage and the Goertzel filter bank.

Parameters:
- NF, 11, number of frequency bins.
- N_ITER, 40, CORDIC iterations per bin; legal range 8..44.

Ports:
- clk  input  1  clock.
- rstn  input  1  asynchronous, active-low reset.
- en  input  1  level enable; a run starts while high, and dropping it aborts or clears the run.
- ang_valid_i  input  1  upstream angle array is valid.
- angle_i  input  [NF-1:0][63:0]  per-bin angle, signed 20.44 radians, legal range [0, 2π).
- valid  output  1  all NF coefficients are written; sticky until en falls.
- busy  output  1  a conversion is in progress.
- range_err_o  output  1  sticky flag: some angle was outside [0, 2π).
- cos_o  output  signed [NF-1:0][63:0]  cos(angle), 20.44.
- sin_o  output  signed [NF-1:0][63:0]  sin(angle), 20.44.
- coef_o  output  signed [NF-1:0][63:0]  2*cos(angle), 20.44.

Behaviour:
- Reset: all outputs are 0, state is IDLE, idx is 0, and the internal snapshot/x/y/z registers are 0. Reset is honoured in any state, including mid-run.
- FSM states: IDLE, LOAD, ROT, STORE, DONE.
- IDLE:
  - Starts when en && ang_valid_i.
  - On start: snapshot angle_i into an internal array, set idx=0, clear range_err_o, busy=1, go to LOAD.
  - Later changes on angle_i or ang_valid_i are ignored until the next run.
- LOAD (1 cycle) — quadrant reduction of a = snap[idx]:
  - a < π/2: theta = a, neg = 0.
  - a < 3π/2: theta = a − π, neg = 1.
  - a < 2π: theta = a − 2π, neg = 0.
  - a < 0 or a ≥ 2π: set range_err_o, then theta = 0, neg = 0, so that bin outputs cos = 1, sin = 0.
  - Then x = CORDIC_K (0.6072529350088813 in 20.44), y = 0, z = theta, iter = 0; go to ROT.
- ROT (N_ITER cycles) — per cycle, i = iter:
  - d = (z ≥ 0) ? +1 : −1.
  - x ← x − d·(y>>>i).
  - y ← y + d·(x>>>i).
  - z ← z − d·ATAN_TAB[i].
  - Arithmetic is 64-bit signed with arithmetic shifts and no rounding; wrap cannot occur for legal inputs.
  - After iter == N_ITER−1, go to STORE.
- STORE (1 cycle):
  - cos_o[idx] ← neg ? −x : x.
  - sin_o[idx] ← neg ? −y : y.
  - coef_o[idx] ← (neg ? −x : x) <<< 1.
  - If idx == NF−1: valid ← 1, busy ← 0, go to DONE. Otherwise idx++ and go to LOAD.
- Latency: valid rises exactly NF*(N_ITER+2) clock edges after the start edge. For the defaults that is 462.
- DONE: holds all outputs. When en is 0: valid ← 0, go to IDLE; outputs are held, not cleared.
- Abort: en low in LOAD, ROT or STORE sends the FSM to IDLE on the next edge with busy = 0 and valid = 0. Bins already stored keep their values; unwritten bins keep their old values. An en low coincident with the final STORE edge aborts: valid stays 0.
- Restart: en must be seen low (IDLE) before a new run; a new run does not clear cos_o, sin_o or coef_o until each bin is rewritten.
- Accuracy: |error| ≤ 2^-36 (256 LSB) vs. the ideal value for N_ITER = 40.

Decomposition:
- Package goertzel_pkg:
  - FW = 44 and DW = 64.
  - Typedef fix_t (logic signed [63:0]).
  - Constants PI, HALF_PI, THREE_HALF_PI, TWO_PI and CORDIC_K in 20.44.
  - ATAN_TAB[0:43] = atan(2^-i) in 20.44.
- One sub-module, cordic_stage: the combinational single-iteration datapath (x, y, z, i → x', y', z'). FSM, snapshot and output arrays stay in the top.

Test Plan:
- Angle 0 on all bins, NF = 11, N_ITER = 40 → valid at exactly 462 cycles after start. Each bin: cos_o = 0x0000100000000000 ±256, sin_o = 0 ±256, coef_o = 0x0000200000000000 ±512.
- Angles π/2, π, 3π/2, π/4 in bins 0..3 → cos ≈ 0, −1.0, 0, 0.70710678 and sin ≈ 1.0, 0, −1.0, 0.70710678, all within ±256 LSB; range_err_o = 0.
- Angle = TWO_PI in bin 5, −1 LSB in bin 6 → range_err_o = 1, both bins output cos = 1.0 and sin = 0; the other bins are correct.
- Drop en at cycle 100 → next edge busy = 0, valid = 0, state IDLE; bins 0..1 are written, bins 2..10 are unchanged. Raising en again yields a full run with valid at 462.
- Assert rstn low mid-ROT → all outputs are 0 immediately. After release with en && ang_valid_i held high, the run completes normally.
- Change angle_i mid-run → outputs match the snapshot taken at the start edge; valid is held until en falls, then clears the next cycle.
